sdram_arbiter: RTL and testbench

Shares the single SDRAM controller port between three requesters: the VGA line-fetch interface, the CPU data port and the blitter. It grants the controller to one requester per transaction and forwards that requester's command. It then routes the controller's ack, read-data and completion strobes back to the owner only. VGA has fixed top priority because it is real-time; CPU and blitter alternate round-robin. A watchdog recovers from a transaction whose completion never arrives.

---
 rtl/sdram_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// SDRAM port arbiter: VGA fixed priority, CPU/blitter round-robin.
// Routes ack/rdvalid/complete to the owner only; watchdog aborts hung transactions.
module sdram_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_req,
  input  logic [25:0] vga_addr,
  input  logic        cpu_req,
  input  logic [25:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  input  logic        blt_req,
  input  logic [25:0] blt_addr,
  input  logic        blt_write,
  input  logic [31:0] blt_wdata,
  input  logic [3:0]  blt_wstrb,
  output logic        vga_ack,
  output logic        cpu_ack,
  output logic        blt_ack,
  output logic        vga_rdvalid,
  output logic        cpu_rdvalid,
  output logic        blt_rdvalid,
  output logic        vga_complete,
  output logic        cpu_complete,
  output logic        blt_complete,
  output logic [31:0] rdata,
  output logic        sdram_req,
  output logic [25:0] sdram_addr,
  output logic        sdram_write,
  output logic        sdram_burst,
  output logic [31:0] sdram_wdata,
  output logic [3:0]  sdram_wstrb,
  input  logic        sdram_ack,
  input  logic [31:0] sdram_rdata,
  input  logic        sdram_rdvalid,
  input  logic        sdram_complete,
  output logic        err_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [1:0] O_NONE = 2'd0;
  localparam logic [1:0] O_VGA  = 2'd1;
  localparam logic [1:0] O_CPU  = 2'd2;
  localparam logic [1:0] O_BLT  = 2'd3;

  localparam logic RR_CPU = 1'b0;
  localparam logic RR_BLT = 1'b1;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [1:0]  owner;
  logic        rr_ptr;
  logic [15:0] wdog;

  logic gnt_vga;
  logic gnt_cpu;
  logic gnt_blt;
  logic in_issue;
  logic in_wait;
  logic expire;
  logic done;

  // word-address low bits are dropped for single-word commands
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{cpu_addr[1:0], blt_addr[1:0]};

  always_comb begin
    gnt_vga = 1'b0;
    gnt_cpu = 1'b0;
    gnt_blt = 1'b0;
    if (state == S_IDLE) begin
      if (vga_req) begin
        gnt_vga = 1'b1;
      end else if (cpu_req && blt_req) begin
        gnt_cpu = (rr_ptr == RR_CPU);
        gnt_blt = (rr_ptr == RR_BLT);
      end else begin
        gnt_cpu = cpu_req;
        gnt_blt = blt_req;
      end
    end
  end

  assign in_issue = (state == S_ISSUE);
  assign in_wait  = (state == S_WAIT);
  assign expire   = in_wait && !sdram_complete
                 && (wdog == WD_LAST);
  assign done     = (in_issue && sdram_ack && sdram_complete)
                 || (in_wait && (sdram_complete || expire));

  assign vga_ack = in_issue && sdram_ack && (owner == O_VGA);
  assign cpu_ack = in_issue && sdram_ack && (owner == O_CPU);
  assign blt_ack = in_issue && sdram_ack && (owner == O_BLT);

  assign vga_rdvalid = in_wait && sdram_rdvalid && (owner == O_VGA);
  assign cpu_rdvalid = in_wait && sdram_rdvalid && (owner == O_CPU);
  assign blt_rdvalid = in_wait && sdram_rdvalid && (owner == O_BLT);

  assign vga_complete = done && (owner == O_VGA);
  assign cpu_complete = done && (owner == O_CPU);
  assign blt_complete = done && (owner == O_BLT);

  assign rdata = sdram_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      owner       <= O_NONE;
      rr_ptr      <= RR_CPU;
      wdog        <= '0;
      sdram_req   <= 1'b0;
      sdram_addr  <= '0;
      sdram_write <= 1'b0;
      sdram_burst <= 1'b0;
      sdram_wdata <= '0;
      sdram_wstrb <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          unique case (1'b1)
            gnt_vga: begin
              owner       <= O_VGA;
              sdram_addr  <= vga_addr;
              sdram_write <= 1'b0;
              sdram_burst <= 1'b1;
              sdram_wdata <= '0;
              sdram_wstrb <= '0;
            end
            gnt_cpu: begin
              owner       <= O_CPU;
              sdram_addr  <= {cpu_addr[25:2], 2'b00};
              sdram_write <= cpu_write;
              sdram_burst <= 1'b0;
              sdram_wdata <= cpu_wdata;
              sdram_wstrb <= cpu_wstrb;
            end
            gnt_blt: begin
              owner       <= O_BLT;
              sdram_addr  <= {blt_addr[25:2], 2'b00};
              sdram_write <= blt_write;
              sdram_burst <= 1'b0;
              sdram_wdata <= blt_wdata;
              sdram_wstrb <= blt_wstrb;
            end
            default: ;
          endcase
          if (gnt_vga || gnt_cpu || gnt_blt) begin
            sdram_req <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            wdog      <= '0;
            if (owner == O_CPU) rr_ptr <= RR_BLT;
            if (owner == O_BLT) rr_ptr <= RR_CPU;
            if (sdram_complete) begin
              state <= S_IDLE;
              owner <= O_NONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (done) begin
            state <= S_IDLE;
            owner <= O_NONE;
            if (expire) err_timeout <= 1'b1;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          owner <= O_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a command scoreboard.
// A controller model answers each command; routing is checked per owner.
module tb_sdram_arbiter;

  localparam int TMO = 24;
  localparam logic [2:0] VGA = 3'b100;
  localparam logic [2:0] CPU = 3'b010;
  localparam logic [2:0] BLT = 3'b001;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_req, cpu_req, blt_req;
  logic [25:0] vga_addr, cpu_addr, blt_addr;
  logic        cpu_write, blt_write;
  logic [31:0] cpu_wdata, blt_wdata;
  logic [3:0]  cpu_wstrb, blt_wstrb;
  logic        vga_ack, cpu_ack, blt_ack;
  logic        vga_rdvalid, cpu_rdvalid, blt_rdvalid;
  logic        vga_complete, cpu_complete, blt_complete;
  logic [31:0] rdata;
  logic        sdram_req;
  logic [25:0] sdram_addr;
  logic        sdram_write, sdram_burst;
  logic [31:0] sdram_wdata;
  logic [3:0]  sdram_wstrb;
  logic        sdram_ack;
  logic [31:0] sdram_rdata;
  logic        sdram_rdvalid, sdram_complete;
  logic        err_timeout;

  always #5 clk = ~clk;

  sdram_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb),
    .blt_req(blt_req), .blt_addr(blt_addr),
    .blt_write(blt_write), .blt_wdata(blt_wdata),
    .blt_wstrb(blt_wstrb),
    .vga_ack(vga_ack), .cpu_ack(cpu_ack), .blt_ack(blt_ack),
    .vga_rdvalid(vga_rdvalid), .cpu_rdvalid(cpu_rdvalid),
    .blt_rdvalid(blt_rdvalid),
    .vga_complete(vga_complete), .cpu_complete(cpu_complete),
    .blt_complete(blt_complete),
    .rdata(rdata),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_write(sdram_write), .sdram_burst(sdram_burst),
    .sdram_wdata(sdram_wdata), .sdram_wstrb(sdram_wstrb),
    .sdram_ack(sdram_ack), .sdram_rdata(sdram_rdata),
    .sdram_rdvalid(sdram_rdvalid),
    .sdram_complete(sdram_complete),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic [2:0]  who;
    logic [25:0] addr;
    logic        write;
    logic        burst;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  cmd_t exp_q[$];
  int total = 0;
  int fails = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] acks();
    return {vga_ack, cpu_ack, blt_ack};
  endfunction
  function automatic logic [2:0] rdvs();
    return {vga_rdvalid, cpu_rdvalid, blt_rdvalid};
  endfunction
  function automatic logic [2:0] cmps();
    return {vga_complete, cpu_complete, blt_complete};
  endfunction

  task automatic push(input logic [2:0] who, input logic [25:0] a,
                      input logic w, input logic [31:0] d,
                      input logic [3:0] s);
    cmd_t c;
    c.who = who;
    if (who == VGA) begin
      c.addr = a; c.write = 1'b0; c.burst = 1'b1;
      c.wdata = '0; c.wstrb = '0;
    end else begin
      c.addr = {a[25:2], 2'b00}; c.write = w; c.burst = 1'b0;
      c.wdata = d; c.wstrb = s;
    end
    exp_q.push_back(c);
  endtask

  task automatic set_req(input logic [2:0] who, input logic [25:0] a,
                         input logic w, input logic [31:0] d,
                         input logic [3:0] s);
    if (who == VGA) begin
      vga_addr = a; vga_req = 1'b1;
    end else if (who == CPU) begin
      cpu_addr = a; cpu_write = w; cpu_wdata = d;
      cpu_wstrb = s; cpu_req = 1'b1;
    end else begin
      blt_addr = a; blt_write = w; blt_wdata = d;
      blt_wstrb = s; blt_req = 1'b1;
    end
  endtask

  task automatic drop(input logic [2:0] who);
    if (who == VGA) vga_req = 1'b0;
    if (who == CPU) cpu_req = 1'b0;
    if (who == BLT) blt_req = 1'b0;
  endtask

  // wait for a command, score it, then ack it (optionally with complete)
  task automatic accept(input int lat, input bit dropit,
                        input bit with_cmp, output logic [2:0] who);
    int n = 0;
    cmd_t e;
    who = 3'b000;
    do begin
      @(negedge clk);
      n++;
    end while (!sdram_req && n < 40);
    chk("req_seen", sdram_req, 1);
    if (!sdram_req) return;
    if (lat > 0) chk("grant_latency", n, lat);
    chk("sb_has_entry", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    who = e.who;
    chk("cmd_addr", sdram_addr, e.addr);
    chk("cmd_write", sdram_write, e.write);
    chk("cmd_burst", sdram_burst, e.burst);
    chk("cmd_wstrb", sdram_wstrb, e.wstrb);
    if (e.write) chk("cmd_wdata", sdram_wdata, e.wdata);
    @(posedge clk); #1;
    sdram_ack = 1'b1;
    sdram_complete = with_cmp;
    @(negedge clk);
    chk("ack_route", acks(), e.who);
    chk("ack_cmp", cmps(), with_cmp ? e.who : 3'b000);
    chk("hold_addr", sdram_addr, e.addr);
    @(posedge clk); #1;
    sdram_ack = 1'b0;
    sdram_complete = 1'b0;
    if (dropit) drop(e.who);
  endtask

  task automatic words(input logic [2:0] who, input int n,
                       input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      sdram_rdvalid = 1'b1;
      sdram_rdata = base + 32'(k);
      @(negedge clk);
      chk("rdv_route", rdvs(), who);
      chk("rdata", rdata, base + 32'(k));
      chk("no_ack_wait", acks(), 3'b000);
    end
    @(posedge clk); #1;
    sdram_rdvalid = 1'b0;
  endtask

  task automatic finish(input logic [2:0] who);
    @(posedge clk); #1;
    sdram_complete = 1'b1;
    @(negedge clk);
    chk("cmp_route", cmps(), who);
    @(posedge clk); #1;
    sdram_complete = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [2:0] who;
    int n;
    reset = 1'b0;
    {vga_req, cpu_req, blt_req} = '0;
    vga_addr = '0; cpu_addr = '0; blt_addr = '0;
    cpu_write = 1'b0; blt_write = 1'b0;
    cpu_wdata = '0; blt_wdata = '0;
    cpu_wstrb = '0; blt_wstrb = '0;
    sdram_ack = 1'b0; sdram_rdata = '0;
    sdram_rdvalid = 1'b0; sdram_complete = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_req", sdram_req, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_cmd", {sdram_write, sdram_burst, sdram_wstrb}, 0);
    chk("rst_wdata", sdram_wdata, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_strobes", {acks(), rdvs(), cmps()}, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // VGA burst alone
    @(posedge clk); #1;
    set_req(VGA, 26'h0001040, 0, 0, 0);
    push(VGA, 26'h0001040, 0, 0, 0);
    accept(2, 1, 0, who);
    words(who, 16, 32'hA000_0000);
    finish(who);

    // strobes while idle are not forwarded
    @(posedge clk); #1;
    sdram_ack = 1; sdram_rdvalid = 1; sdram_complete = 1;
    @(negedge clk);
    chk("idle_strobes", {acks(), rdvs(), cmps()}, 0);
    chk("idle_no_req", sdram_req, 0);
    @(posedge clk); #1;
    sdram_ack = 0; sdram_rdvalid = 0; sdram_complete = 0;

    // CPU and blitter held: round-robin
    @(posedge clk); #1;
    set_req(CPU, 26'h0000300, 0, 0, 4'hF);
    set_req(BLT, 26'h0000400, 1, 32'h0BAD_F00D, 4'hC);
    push(CPU, 26'h0000300, 0, 0, 4'hF);
    push(BLT, 26'h0000400, 1, 32'h0BAD_F00D, 4'hC);
    push(CPU, 26'h0000300, 0, 0, 4'hF);
    push(BLT, 26'h0000400, 1, 32'h0BAD_F00D, 4'hC);
    for (int i = 0; i < 4; i++) begin
      accept(2, 0, 0, who);
      if (i == 3) begin
        drop(CPU);
        drop(BLT);
      end
      if (who == CPU) words(who, 1, 32'hC000_0000 + 32'(i));
      finish(who);
    end

    // CPU write with unaligned address
    @(posedge clk); #1;
    set_req(CPU, 26'h0000106, 1, 32'hDEAD_BEEF, 4'h3);
    push(CPU, 26'h0000106, 1, 32'hDEAD_BEEF, 4'h3);
    accept(2, 1, 0, who);
    finish(who);

    // blitter: complete in the same cycle as ack
    @(posedge clk); #1;
    set_req(BLT, 26'h0000208, 1, 32'h1234_5678, 4'hF);
    push(BLT, 26'h0000208, 1, 32'h1234_5678, 4'hF);
    accept(2, 1, 1, who);

    // VGA arrives during CPU transaction with blitter pending
    @(posedge clk); #1;
    set_req(CPU, 26'h0000500, 0, 0, 4'hF);
    set_req(BLT, 26'h0000600, 0, 0, 4'hF);
    push(CPU, 26'h0000500, 0, 0, 4'hF);
    accept(2, 1, 0, who);
    set_req(VGA, 26'h0002040, 0, 0, 0);
    push(VGA, 26'h0002040, 0, 0, 0);
    push(BLT, 26'h0000600, 0, 0, 4'hF);
    words(who, 1, 32'h5555_0000);
    finish(who);
    accept(2, 1, 0, who);
    words(who, 16, 32'h6000_0000);
    finish(who);
    accept(2, 1, 0, who);
    words(who, 1, 32'h7777_0000);
    finish(who);

    // watchdog: acked but never completed
    @(posedge clk); #1;
    set_req(CPU, 26'h0000700, 0, 0, 4'hF);
    push(CPU, 26'h0000700, 0, 0, 4'hF);
    accept(2, 1, 0, who);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cmps() == 3'b000 && n < TMO + 5);
    chk("tmo_cycles", n, TMO);
    chk("tmo_owner", cmps(), CPU);
    chk("tmo_err_pre", err_timeout, 0);
    @(negedge clk);
    chk("tmo_err_set", err_timeout, 1);
    @(posedge clk); #1;
    set_req(BLT, 26'h0000800, 1, 32'hCAFE_0001, 4'h1);
    push(BLT, 26'h0000800, 1, 32'hCAFE_0001, 4'h1);
    accept(2, 1, 0, who);
    finish(who);
    chk("tmo_err_sticky", err_timeout, 1);

    // reset in the middle of a burst
    @(posedge clk); #1;
    set_req(VGA, 26'h0003000, 0, 0, 0);
    push(VGA, 26'h0003000, 0, 0, 0);
    accept(2, 1, 0, who);
    words(who, 5, 32'h9000_0000);
    @(posedge clk); #1;
    sdram_rdvalid = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", sdram_req, 0);
    chk("mid_rst_addr", sdram_addr, 0);
    chk("mid_rst_cmd", {sdram_write, sdram_burst, sdram_wstrb}, 0);
    chk("mid_rst_err", err_timeout, 0);
    chk("mid_rst_strobes", {acks(), rdvs(), cmps()}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    sdram_complete = 1'b1;
    @(negedge clk);
    chk("late_strobes", {rdvs(), cmps()}, 0);
    chk("late_no_req", sdram_req, 0);
    @(posedge clk); #1;
    sdram_rdvalid = 1'b0;
    sdram_complete = 1'b0;
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
